// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Purpose  : Shared types, constants and helpers for the TDC edge decoder.
// Revision : 1.0  initial release
// ============================================================================
package tdc_pkg;

    localparam int TDC_N_TAPS = 64;
    localparam int TDC_W      = 6;

    typedef logic [TDC_N_TAPS-1:0] tdc_code_t;
    typedef logic [TDC_W-1:0]      tdc_pos_t;

    typedef struct packed {
        tdc_pos_t pos;
        logic     ok;
    } tdc_edge_t;

    // Transition polarity searched for by the first-edge encoder
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } tdc_pol_e;

    // Three-input majority vote used by the bubble filter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_edge_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : tdc_edge_decoder_if
// Purpose  : Sample input and decoded-edge result bundle of the TDC decoder.
//            master = capture-bank side, slave = decoder side.
// Revision : 1.0  initial release
// ============================================================================
interface tdc_edge_decoder_if
    import tdc_pkg::*;
#(
    parameter int N_TAPS = TDC_N_TAPS,
    parameter int W      = $clog2(N_TAPS)
);
    logic              tdc_en;
    logic [N_TAPS-1:0] tq;
    logic              valid;
    logic [W-1:0]      rise_pos;
    logic [W-1:0]      fall_pos;
    logic              rise_ok;
    logic              fall_ok;
    logic              no_edge;
    logic [W-1:0]      half_per;

    modport master (
        output tdc_en, tq,
        input  valid, rise_pos, fall_pos, rise_ok, fall_ok, no_edge, half_per
    );

    modport slave (
        input  tdc_en, tq,
        output valid, rise_pos, fall_pos, rise_ok, fall_ok, no_edge, half_per
    );

endinterface : tdc_edge_decoder_if
`default_nettype wire

// File: rtl/tdc_first_edge_enc.sv
`default_nettype none
// ============================================================================
// Module   : tdc_first_edge_enc
// Purpose  : Priority encoder returning the lowest tap index i (1..N-1) where
//            the code shows a transition of polarity POL between i-1 and i.
// Revision : 1.0  initial release
// ============================================================================
module tdc_first_edge_enc
    import tdc_pkg::*;
#(
    parameter int       N   = TDC_N_TAPS,
    parameter int       W   = $clog2(N),
    parameter tdc_pol_e POL = EDGE_RISE
) (
    input  wire logic [N-1:0] code,
    output logic      [W-1:0] pos,
    output logic              ok
);

    // Level found on the later tap of a matching transition
    localparam logic C_AFTER = (POL == EDGE_RISE);

    // Scan downward so the last hit written is the smallest index
    always_comb begin
        pos = '0;
        ok  = 1'b0;
        for (int i = N - 1; i >= 1; i--) begin
            if ((code[i] == C_AFTER) && (code[i-1] != C_AFTER)) begin
                pos = W'(i);
                ok  = 1'b1;
            end
        end
    end

endmodule : tdc_first_edge_enc
`default_nettype wire

// File: rtl/tdc_edge_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tdc_edge_decoder
// Purpose  : Bubble-corrects a TDC delay-line snapshot and reports the first
//            rising/falling tap positions and the half-period in taps.
//            Three register ranks: input, filtered code, result.
// Revision : 1.0  initial release
// ============================================================================
module tdc_edge_decoder
    import tdc_pkg::*;
#(
    parameter int N_TAPS = TDC_N_TAPS,
    parameter int W      = $clog2(N_TAPS)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    tdc_edge_decoder_if.slave  bus
);

    logic [N_TAPS-1:0] r_s1_tq;
    logic              r_s1_en;
    logic [N_TAPS-1:0] w_code;
    logic [N_TAPS-1:0] r_s2_code;
    logic              r_s2_en;

    tdc_edge_t         w_rise;
    tdc_edge_t         w_fall;
    logic [W-1:0]      w_diff;

    logic              r_valid;
    logic [W-1:0]      r_rise_pos;
    logic [W-1:0]      r_fall_pos;
    logic              r_rise_ok;
    logic              r_fall_ok;
    logic              r_no_edge;
    logic [W-1:0]      r_half_per;

    // Stage 1: capture the raw snapshot and its qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_tq <= '0;
            r_s1_en <= 1'b0;
        end else begin
            r_s1_tq <= bus.tq;
            r_s1_en <= bus.tdc_en;
        end
    end

    // Majority filter over each tap and its neighbours; edges replicate
    for (genvar i = 0; i < N_TAPS; i++) begin : g_bubble
        localparam int LO = (i == 0)          ? 0 : i - 1;
        localparam int HI = (i == N_TAPS - 1) ? i : i + 1;
        assign w_code[i] = maj3(r_s1_tq[LO], r_s1_tq[i], r_s1_tq[HI]);
    end

    // Stage 2: hold the bubble-corrected code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_code <= '0;
            r_s2_en   <= 1'b0;
        end else begin
            r_s2_code <= w_code;
            r_s2_en   <= r_s1_en;
        end
    end

    tdc_first_edge_enc #(
        .N   (N_TAPS),
        .W   (W),
        .POL (EDGE_RISE)
    ) u_rise_enc (
        .code (r_s2_code),
        .pos  (w_rise.pos),
        .ok   (w_rise.ok)
    );

    tdc_first_edge_enc #(
        .N   (N_TAPS),
        .W   (W),
        .POL (EDGE_FALL)
    ) u_fall_enc (
        .code (r_s2_code),
        .pos  (w_fall.pos),
        .ok   (w_fall.ok)
    );

    assign w_diff = (w_fall.pos > w_rise.pos) ? (w_fall.pos - w_rise.pos)
                                              : (w_rise.pos - w_fall.pos);

    // Stage 3: result register; data loads only for qualified samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rise_pos <= '0;
            r_fall_pos <= '0;
            r_rise_ok  <= 1'b0;
            r_fall_ok  <= 1'b0;
            r_no_edge  <= 1'b0;
            r_half_per <= '0;
        end else begin
            r_valid <= r_s2_en;
            if (r_s2_en) begin
                r_rise_pos <= w_rise.pos;
                r_fall_pos <= w_fall.pos;
                r_rise_ok  <= w_rise.ok;
                r_fall_ok  <= w_fall.ok;
                r_no_edge  <= ~w_rise.ok & ~w_fall.ok;
                // Half-period only refreshes when both edges are present
                if (w_rise.ok && w_fall.ok) begin
                    r_half_per <= w_diff;
                end
            end
        end
    end

    assign bus.valid    = r_valid;
    assign bus.rise_pos = r_rise_pos;
    assign bus.fall_pos = r_fall_pos;
    assign bus.rise_ok  = r_rise_ok;
    assign bus.fall_ok  = r_fall_ok;
    assign bus.no_edge  = r_no_edge;
    assign bus.half_per = r_half_per;

endmodule : tdc_edge_decoder
`default_nettype wire
